// File: rtl/fp32_pkg.sv
// Shared binary32 constants and types for the FP32 arithmetic library
// (divider, multiplier).
package fp32_pkg;

    localparam int          FP32_BIAS    = 127;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
    localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_snan;
    } fp32_class_t;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM
    } div_state_t;

endpackage

// File: rtl/fp32_divider_if.sv
// Operand/result bundle of the FP32 divider. The master side drives the
// operands and the slave (the divider) returns the quotient and flags.
interface fp32_divider_if;

    logic        valid_i;
    logic [31:0] A;
    logic [31:0] B;
    logic        ready_o;
    logic [31:0] result_o;
    logic        done_o;
    logic        overflow_o;
    logic        underflow_o;
    logic        invalid_o;
    logic        div_by_zero_o;

    modport master (
        output valid_i, A, B,
        input  ready_o, result_o, done_o, overflow_o, underflow_o, invalid_o, div_by_zero_o
    );

    modport slave (
        input  valid_i, A, B,
        output ready_o, result_o, done_o, overflow_o, underflow_o, invalid_o, div_by_zero_o
    );

endinterface

// File: rtl/fp32_unpack.sv
// Combinational classification of one binary32 operand plus hidden-bit
// significand extraction. Subnormals classify as zero (flush-to-zero).
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0] op,
    output fp32_class_t cls,
    output logic [7:0]  exp,
    output logic [23:0] sig
);

    logic [22:0] man;

    assign exp = op[30:23];
    assign man = op[22:0];
    assign sig = {1'b1, man};

    assign cls.is_zero = (exp == 8'd0);
    assign cls.is_inf  = (exp == FP32_EXP_MAX) && (man == 23'd0);
    assign cls.is_nan  = (exp == FP32_EXP_MAX) && (man != 23'd0);
    assign cls.is_snan = cls.is_nan && !man[22];

endmodule

// File: rtl/fp32_divider.sv
// Iterative binary32 divider: radix-2 restoring mantissa division, one
// quotient bit per cycle, fixed 26-cycle latency, truncating, FTZ.
module fp32_divider
    import fp32_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    fp32_divider_if.slave  bus
);

    div_state_t         state, state_nxt;
    fp32_class_t        cls_a, cls_b, cls_a_q, cls_b_q;
    logic [7:0]         exp_a, exp_b;
    logic [23:0]        sig_a, sig_b;
    logic               sign_q;
    logic signed [9:0]  e_q;
    logic [25:0]        rem_q;
    logic [23:0]        d_q;
    logic [24:0]        q_q;
    logic [4:0]         cnt_q;

    logic signed [9:0]  e_n;
    logic [22:0]        man_n;
    logic [31:0]        res_n;
    logic               ovf_n, unf_n, inv_n, dbz_n;
    logic               special_a, special_b;

    fp32_unpack u_unpack_a (.op(bus.A), .cls(cls_a), .exp(exp_a), .sig(sig_a));
    fp32_unpack u_unpack_b (.op(bus.B), .cls(cls_b), .exp(exp_b), .sig(sig_b));

    assign special_a = cls_a.is_zero | cls_a.is_inf | cls_a.is_nan;
    assign special_b = cls_b.is_zero | cls_b.is_inf | cls_b.is_nan;

    assign bus.ready_o = (state == IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.valid_i) state_nxt = DIV;
            DIV:     if (cnt_q == 5'd0) state_nxt = NORM;
            NORM:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result selection: special-operand cases override the arithmetic path.
    always_comb begin
        e_n   = q_q[24] ? e_q : e_q - 10'sd1;
        man_n = q_q[24] ? q_q[23:1] : q_q[22:0];
        res_n = {sign_q, e_n[7:0], man_n};
        ovf_n = 1'b0;
        unf_n = 1'b0;
        inv_n = 1'b0;
        dbz_n = 1'b0;
        if (cls_a_q.is_nan || cls_b_q.is_nan || (cls_a_q.is_zero && cls_b_q.is_zero) ||
            (cls_a_q.is_inf && cls_b_q.is_inf)) begin
            res_n = FP32_QNAN;
            inv_n = (cls_a_q.is_zero && cls_b_q.is_zero) || (cls_a_q.is_inf && cls_b_q.is_inf) ||
                    cls_a_q.is_snan || cls_b_q.is_snan;
        end else if (cls_a_q.is_inf) begin
            res_n = {sign_q, FP32_EXP_MAX, 23'd0};
        end else if (cls_b_q.is_zero) begin
            res_n = {sign_q, FP32_EXP_MAX, 23'd0};
            dbz_n = 1'b1;
        end else if (cls_a_q.is_zero || cls_b_q.is_inf) begin
            res_n = {sign_q, 31'd0};
        end else if (e_n >= 10'sd255) begin
            res_n = {sign_q, FP32_EXP_MAX, 23'd0};
            ovf_n = 1'b1;
        end else if (e_n <= 10'sd0) begin
            res_n = {sign_q, 31'd0};
            unf_n = 1'b1;
        end
    end

    // Operand capture, restoring divide iterations and result registration.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sign_q            <= 1'b0;
            cls_a_q           <= '0;
            cls_b_q           <= '0;
            e_q               <= '0;
            rem_q             <= '0;
            d_q               <= '0;
            q_q               <= '0;
            cnt_q             <= '0;
            bus.result_o      <= '0;
            bus.done_o        <= 1'b0;
            bus.overflow_o    <= 1'b0;
            bus.underflow_o   <= 1'b0;
            bus.invalid_o     <= 1'b0;
            bus.div_by_zero_o <= 1'b0;
        end else begin
            bus.done_o        <= 1'b0;
            bus.overflow_o    <= 1'b0;
            bus.underflow_o   <= 1'b0;
            bus.invalid_o     <= 1'b0;
            bus.div_by_zero_o <= 1'b0;
            case (state)
                IDLE: if (bus.valid_i) begin
                    sign_q  <= bus.A[31] ^ bus.B[31];
                    cls_a_q <= cls_a;
                    cls_b_q <= cls_b;
                    e_q     <= {2'b00, exp_a} - {2'b00, exp_b} + 10'(FP32_BIAS);
                    rem_q   <= {2'b00, special_a ? 24'h800000 : sig_a};
                    d_q     <= special_b ? 24'h800000 : sig_b;
                    q_q     <= '0;
                    cnt_q   <= 5'd24;
                end
                DIV: begin
                    if (rem_q >= {2'b00, d_q}) begin
                        q_q[cnt_q] <= 1'b1;
                        rem_q      <= (rem_q - {2'b00, d_q}) << 1;
                    end else begin
                        rem_q      <= rem_q << 1;
                    end
                    cnt_q <= cnt_q - 5'd1;
                end
                NORM: begin
                    bus.result_o      <= res_n;
                    bus.done_o        <= 1'b1;
                    bus.overflow_o    <= ovf_n;
                    bus.underflow_o   <= unf_n;
                    bus.invalid_o     <= inv_n;
                    bus.div_by_zero_o <= dbz_n;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_divider.sv
// Directed self-checking bench for fp32_divider: special cases, rounding,
// latency, handshake throughput and mid-operation reset.
module tb_fp32_divider;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    fp32_divider_if bus ();

    fp32_divider dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    int tests    = 0;
    int failures = 0;
    int accepts  = 0;
    int dones    = 0;
    bit count_en = 1'b0;
    int lat;

    // Handshake events are counted mid-cycle, where inputs and outputs are stable.
    always @(negedge clk_i) begin
        if (count_en) begin
            if (bus.valid_i && bus.ready_o) accepts++;
            if (bus.done_o)                 dones++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, bus.overflow_o, bus.underflow_o, bus.invalid_o, bus.div_by_zero_o};
    endfunction

    // Issues one operation and waits (bounded) for done_o; returns cycles from accept.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, output int cycles);
        bus.valid_i = 1'b1;
        bus.A       = a;
        bus.B       = b;
        @(posedge clk_i);
        #1;
        bus.valid_i = 1'b0;
        bus.A       = 32'hDEADBEEF;
        bus.B       = 32'h12345678;
        cycles      = 0;
        while (cycles < 40) begin
            @(posedge clk_i);
            cycles++;
            #1;
            if (bus.done_o) break;
        end
    endtask

    // flag vector order: {overflow, underflow, invalid, div_by_zero}
    task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic [3:0] exp_flags);
        check_output({tag, "_ready"}, {31'd0, bus.ready_o}, 32'd1);
        apply_stimulus(a, b, lat);
        check_output({tag, "_latency"}, lat, 32'd26);
        check_output({tag, "_result"}, bus.result_o, exp_res);
        check_output({tag, "_flags"}, flags(), {28'd0, exp_flags});
        @(posedge clk_i);
        #1;
        check_output({tag, "_done_clear"}, {31'd0, bus.done_o}, 32'd0);
        check_output({tag, "_flags_clear"}, flags(), 32'd0);
        check_output({tag, "_result_hold"}, bus.result_o, exp_res);
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.A       = 32'd0;
        bus.B       = 32'd0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check_output("reset_ready", {31'd0, bus.ready_o}, 32'd1);
        check_output("reset_done", {31'd0, bus.done_o}, 32'd0);
        check_output("reset_result", bus.result_o, 32'd0);
        check_output("reset_flags", flags(), 32'd0);

        run_case("six_div_two", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);
        run_case("one_div_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000);
        run_case("one_div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001);
        run_case("zero_div_zero", 32'h80000000, 32'h00000000, 32'h7FC00000, 4'b0010);
        run_case("overflow", 32'h7F000000, 32'h3F000000, 32'h7F800000, 4'b1000);
        run_case("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 4'b0100);
        run_case("inf_div_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0010);
        run_case("snan_div_one", 32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b0010);
        run_case("neg_inf_div_two", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
        run_case("neg_one_div_inf", 32'hBF800000, 32'h7F800000, 32'h80000000, 4'b0000);
        run_case("qnan_div_one", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000);

        // 50 edges of continuous valid_i: accepts land at k and k+27 only.
        bus.A       = 32'h40C00000;
        bus.B       = 32'h40000000;
        bus.valid_i = 1'b1;
        accepts     = 0;
        dones       = 0;
        count_en    = 1'b1;
        repeat (50) @(posedge clk_i);
        #1;
        bus.valid_i = 1'b0;
        repeat (30) @(posedge clk_i);
        #1;
        count_en = 1'b0;
        check_output("stream_accepts", accepts, 32'd2);
        check_output("stream_dones", dones, 32'd2);
        check_output("stream_result", bus.result_o, 32'h40400000);

        // Reset ten cycles into an operation must abandon it silently.
        dones    = 0;
        count_en = 1'b1;
        apply_stimulus_abort();
        check_output("abort_ready", {31'd0, bus.ready_o}, 32'd1);
        check_output("abort_done", {31'd0, bus.done_o}, 32'd0);
        repeat (40) @(posedge clk_i);
        #1;
        count_en = 1'b0;
        check_output("abort_no_done", dones, 32'd0);
        check_output("abort_result", bus.result_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    task automatic apply_stimulus_abort();
        bus.A       = 32'h3F800000;
        bus.B       = 32'h40400000;
        bus.valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus.valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

endmodule
